// File: rtl/irq_pkg.sv
// Shared parameters, FSM state type and vector payload for the interrupt vector controller.
package irq_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam logic [31:0] VEC_BASE = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Vector address: fixed upper base bits with the source index in the low bits.
    typedef struct packed {
        logic [31-IDX_W:0] base;
        logic [IDX_W-1:0]  id;
    } irq_vec_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational highest-index priority encoder over the eligible interrupt sources.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   sel,
    output logic               any
);

    // Ascending scan so the highest set index is the one left in sel.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                sel = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Registered interrupt scheduler: sticky edge capture, masking, highest-index selection
// and a req/ack/EOI handshake presenting one vector address at a time.
module irq_vector_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] done,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wd,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [31:0]        int_addr,
    output logic [IDX_W-1:0]   int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               in_service
);

    irq_state_e         state, state_n;
    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] rise, elig, clr;
    logic [NUM_SRC-1:0] pending_n, mask_n;
    logic [IDX_W-1:0]   sel, int_id_n;
    logic               any, int_req_n, in_service_n;
    irq_vec_t           vec_n;

    assign rise = done & ~done_q;
    assign elig = pending & mask;

    irq_prio_enc u_prio_enc (
        .req (elig),
        .sel (sel),
        .any (any)
    );

    // Handshake sequencing; int_id returns to 0 in IDLE so int_addr reads VEC_BASE.
    always_comb begin
        state_n      = state;
        int_req_n    = int_req;
        int_id_n     = int_id;
        in_service_n = in_service;
        clr          = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_n   = REQ;
                    int_req_n = 1'b1;
                    int_id_n  = sel;
                end
            end
            REQ: begin
                if (int_ack) begin
                    clr          = NUM_SRC'(1) << int_id;
                    state_n      = SERVICE;
                    int_req_n    = 1'b0;
                    in_service_n = 1'b1;
                end else if (!any) begin
                    state_n   = IDLE;
                    int_req_n = 1'b0;
                    int_id_n  = '0;
                end else begin
                    int_id_n = sel;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_n      = IDLE;
                    in_service_n = 1'b0;
                    int_id_n     = '0;
                end
            end
            default: begin
                state_n      = IDLE;
                int_req_n    = 1'b0;
                in_service_n = 1'b0;
                int_id_n     = '0;
            end
        endcase
        // A new rise wins over the acknowledge clear on the same bit.
        pending_n  = (pending & ~clr) | rise;
        mask_n     = mask_we ? mask_wd : mask;
        vec_n.base = VEC_BASE[31:IDX_W];
        vec_n.id   = int_id_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done_q     <= '0;
            pending    <= '0;
            mask       <= '1;
            int_req    <= 1'b0;
            int_id     <= '0;
            int_addr   <= VEC_BASE;
            in_service <= 1'b0;
        end else begin
            state      <= state_n;
            done_q     <= done;
            pending    <= pending_n;
            mask       <= mask_n;
            int_req    <= int_req_n;
            int_id     <= int_id_n;
            int_addr   <= vec_n;
            in_service <= in_service_n;
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl with a scoreboard of expected vectors checked on each new request.
module tb_irq_vector_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  done;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        int_ack;
    logic        eoi;
    logic        int_req;
    logic [31:0] int_addr;
    logic [1:0]  int_id;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic        in_service;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_req = 1'b0;

    irq_vector_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done       (done),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_addr   (int_addr),
        .int_id     (int_id),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_vec(input logic [1:0] id, input logic [31:0] addr);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // On each new request, the presented vector must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && int_req && !prev_req) begin
            chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_addr", int_addr, e.addr);
                chk("sb_id", 32'(int_id), 32'(e.id));
            end
        end
        prev_req = int_req;
    end

    initial begin
        rst_n   = 1'b0;
        done    = '0;
        mask_we = 1'b0;
        mask_wd = '0;
        int_ack = 1'b0;
        eoi     = 1'b0;
        tick(2);
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_addr", int_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        tick(2);

        // Idle after reset
        chk("idle_int_req", 32'(int_req), 32'd0);
        chk("idle_addr", int_addr, 32'hFFFF_FFFC);
        chk("idle_pending", 32'(pending), 32'h0);
        chk("idle_mask", 32'(mask), 32'hF);
        chk("idle_in_service", 32'(in_service), 32'd0);

        // Single source: done1
        done = 4'b0001;
        tick();
        chk("s1_pending_set", 32'(pending), 32'h1);
        chk("s1_req_not_yet", 32'(int_req), 32'd0);
        expect_vec(2'd0, 32'hFFFF_FFFC);
        tick();
        chk("s1_req_high", 32'(int_req), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("s1_ack_req_low", 32'(int_req), 32'd0);
        chk("s1_ack_in_service", 32'(in_service), 32'd1);
        chk("s1_ack_pending_clr", 32'(pending), 32'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("s1_eoi_in_service", 32'(in_service), 32'd0);
        chk("s1_eoi_addr", int_addr, 32'hFFFF_FFFC);
        done = '0;
        tick(2);

        // Priority and preemption: done2 then done3 a cycle later
        done = 4'b0010;
        tick();
        done = 4'b0110;
        expect_vec(2'd1, 32'hFFFF_FFFD);
        tick();
        tick();
        chk("pre_id", 32'(int_id), 32'd2);
        chk("pre_addr", int_addr, 32'hFFFF_FFFE);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("pre_ack_pending", 32'(pending), 32'h2);
        expect_vec(2'd1, 32'hFFFF_FFFD);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("pre_next_id", 32'(int_id), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("pre_done_pending", 32'(pending), 32'h0);
        done = '0;
        tick(2);

        // Simultaneous done4 and done1
        done = 4'b1001;
        tick();
        chk("sim_pending", 32'(pending), 32'h9);
        expect_vec(2'd3, 32'hFFFF_FFFF);
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("sim_ack_pending", 32'(pending), 32'h1);
        expect_vec(2'd0, 32'hFFFF_FFFC);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("sim_second_req", 32'(int_req), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        done = '0;
        tick(2);

        // Masking holds done4 pending without a request
        mask_we = 1'b1;
        mask_wd = 4'b0111;
        tick();
        mask_we = 1'b0;
        chk("mask_written", 32'(mask), 32'h7);
        done = 4'b1000;
        tick();
        chk("mask_pending", 32'(pending), 32'h8);
        tick(2);
        chk("mask_no_req", 32'(int_req), 32'd0);
        mask_we = 1'b1;
        mask_wd = 4'b1111;
        expect_vec(2'd3, 32'hFFFF_FFFF);
        tick();
        mask_we = 1'b0;
        chk("unmask_req_wait", 32'(int_req), 32'd0);
        tick();
        chk("unmask_req", 32'(int_req), 32'd1);
        chk("unmask_id", 32'(int_id), 32'd3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        done = '0;
        tick(2);

        // Re-rise of the serviced source during SERVICE
        done = 4'b0001;
        tick();
        expect_vec(2'd0, 32'hFFFF_FFFC);
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        done = '0;
        tick();
        done = 4'b0001;
        tick();
        chk("rerise_pending", 32'(pending), 32'h1);
        chk("rerise_in_service", 32'(in_service), 32'd1);
        chk("rerise_no_req", 32'(int_req), 32'd0);
        expect_vec(2'd0, 32'hFFFF_FFFC);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("rerise_served", 32'(int_req), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        done = 4'b0011;
        tick();
        chk("svc_pending_acc", 32'(pending), 32'h2);

        // Asynchronous reset during SERVICE
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_service", 32'(in_service), 32'd0);
        chk("arst_pending", 32'(pending), 32'h0);
        chk("arst_int_req", 32'(int_req), 32'd0);
        chk("arst_addr", int_addr, 32'hFFFF_FFFC);
        chk("arst_mask", 32'(mask), 32'hF);
        tick();
        done  = '0;
        rst_n = 1'b1;
        tick(3);
        chk("final_int_req", 32'(int_req), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
- Sequences buffer-completion interrupts from the four accelerator buffers (done1..done4) to the CPU.
- Captures done rising edges into sticky pending flags, applies a per-source mask and selects the highest-index eligible source.
- Runs a req/ack/EOI handshake with the CPU and presents the vector address {30'h3FFFFFFF, id}.
- Replaces the purely combinational vector encoder with a registered, glitch-free, one-at-a-time scheduler.

Parameters:
- NUM_SRC, 4: number of interrupt sources.
- IDX_W, 2: source index width (log2 NUM_SRC).
- VEC_BASE, 32'hFFFF_FFFC: vector base; int_addr = {VEC_BASE[31:IDX_W], id}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done  in  NUM_SRC  level completion flags; bit i = buffer i+1.
- mask_we  in  1  one-cycle write strobe for mask.
- mask_wd  in  NUM_SRC  new mask value; 1 = enabled.
- int_ack  in  1  CPU accepts the current request.
- eoi  in  1  one-cycle end-of-interrupt pulse from the ISR.
- int_req  out  1  interrupt request to CPU.
- int_addr  out  32  vector address.
- int_id  out  IDX_W  selected source index.
- pending  out  NUM_SRC  sticky pending flags (status).
- mask  out  NUM_SRC  current mask.
- in_service  out  1  high while the ISR is active.

Behaviour:
- Reset values (asynchronous): done_q=0, pending=0, mask=all 1s, state=IDLE, int_req=0, int_id=0, int_addr=VEC_BASE, in_service=0.
- Edge capture: rise = done & ~done_q, with done_q registered each cycle.
  - pending_next = (pending & ~clr) | rise. Set wins over clear on the same bit.
  - A rise on an already-pending bit is coalesced (lost).
- Eligibility: elig = pending & mask. Selection picks the highest set index (4 > 3 > 2 > 1).
- Mask: mask_we loads mask_wd at the clock edge. Masking never clears pending.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if elig != 0, go to REQ. Register int_id = sel and int_req = 1 at that edge.
  - REQ: int_req = 1. int_id re-evaluates every cycle to the current highest eligible source, so a higher-priority source preempts before ack.
  - REQ, elig becomes 0 (mask write): return to IDLE, int_req = 0 next cycle.
  - REQ, int_ack = 1 sampled: clear pending[int_id], freeze int_id, go to SERVICE. int_req = 0 and in_service = 1 from the next cycle.
  - SERVICE: wait for eoi, then go to IDLE with in_service = 0. New rises still accumulate. There is no nesting.
- int_addr = {VEC_BASE[31:IDX_W], int_id}, registered.
  - Equals VEC_BASE in IDLE.
  - Valid whenever int_req or in_service is high.
- Latency: done rises before edge k → pending set after edge k → int_req high after edge k+1 (2 cycles).
- ack to int_req low is 1 cycle. eoi to the next int_req (if elig != 0) is 2 cycles: IDLE, then REQ.
- Ignored inputs: int_ack outside REQ, eoi outside SERVICE.
- Simultaneous int_ack and a higher-priority rise in the same cycle: the ack binds to the int_id shown that cycle.
- Reset asserted mid-handshake: all state returns to reset values immediately. Pending events are discarded.

Decomposition:
- Shared package irq_pkg: NUM_SRC, IDX_W, VEC_BASE, FSM state enum {IDLE, REQ, SERVICE}.
- One sub-module, irq_prio_enc: combinational highest-index encoder with outputs sel[IDX_W-1:0] and any.

Test Plan:
- Idle after reset: no done → int_req=0, int_addr=32'hFFFFFFFC, pending=4'b0000, mask=4'b1111.
- Single source: done1 rises → int_req=1 two edges later, int_addr=32'hFFFFFFFC, int_id=0.
  - Then int_ack → int_req=0 next cycle, pending[0]=0, in_service=1.
  - Then eoi → IDLE.
- Priority and preemption:
  - done2 then done3 one cycle later, before ack → int_id=2, int_addr=32'hFFFFFFFE at ack.
  - After eoi → int_id=1 (addr ...FFFD) is served next.
- Simultaneous sources: done4 and done1 in the same cycle → int_addr=32'hFFFFFFFF.
  - After ack+eoi → 32'hFFFFFFFC.
- Masking: mask_wd=4'b0111, done4 rises → pending=4'b1000, int_req=0.
  - Write mask 4'b1111 → int_req=1 next cycle, int_id=3.
- Reset and edge cases:
  - rst_n low during SERVICE → in_service=0 and pending=0 asynchronously.
  - A re-rise of the serviced source during SERVICE sets pending again, and it is served after eoi.
